// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the program-3 pattern scan sequencer.
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_WR0,
        S_WR1,
        S_WR2,
        S_DONE
    } scan_state_t;

    localparam int DEF_STR_BYTES = 32;
    localparam int DEF_PAT_ADDR  = 32;
    localparam int DEF_RES_ADDR  = 33;
    localparam int DEF_AW        = 8;

    localparam int PAT_W = 5;
    localparam int CNT_W = 8;

endpackage

// File: rtl/pattern_scan_ctrl_match.sv
// Window comparator: counts pattern hits inside the current byte and across
// the boundary with the previous byte's low nibble.
module pattern_window_match
    import pattern_scan_pkg::*;
(
    input  logic [PAT_W-1:0] pat,
    input  logic [11:0]      w,
    input  logic             first,
    output logic [2:0]       in_cnt,
    output logic             in_any,
    output logic [2:0]       cross_cnt
);

    // w[k+:5] for k=0..3 are the in-byte windows; w[k+4+:5] straddle the boundary
    always_comb begin
        in_cnt    = '0;
        cross_cnt = '0;
        in_any    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w[k +: PAT_W] == pat)
                in_cnt = in_cnt + 3'd1;
            if (!first && (w[k+4 +: PAT_W] == pat))
                cross_cnt = cross_cnt + 3'd1;
        end
        in_any = (in_cnt != 3'd0);
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Data-memory sequencer: loads a 5-bit pattern, scans the string bytes and
// writes the in-byte, per-byte and crossing match counts back to memory.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int STR_BYTES = DEF_STR_BYTES,
    parameter int PAT_ADDR  = DEF_PAT_ADDR,
    parameter int RES_ADDR  = DEF_RES_ADDR,
    parameter int AW        = DEF_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam logic [AW-1:0] LAST_IDX = AW'(STR_BYTES - 1);

    scan_state_t      state, next_state;
    logic [PAT_W-1:0] pat;
    logic [3:0]       prev;
    logic [AW-1:0]    idx;
    logic [CNT_W-1:0] ctb, cto, cts;

    logic [2:0]       in_cnt, cross_cnt;
    logic             in_any;

    pattern_window_match u_match (
        .pat       (pat),
        .w         ({prev, mem_rd_data}),
        .first     (idx == '0),
        .in_cnt    (in_cnt),
        .in_any    (in_any),
        .cross_cnt (cross_cnt)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and DM port decode; outputs depend only on registered state
    always_comb begin
        next_state  = state;
        ack         = 1'b0;
        busy        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            S_IDLE: if (req) next_state = S_LOAD;
            S_LOAD: begin
                busy       = 1'b1;
                mem_addr   = AW'(PAT_ADDR);
                next_state = S_SCAN;
            end
            S_SCAN: begin
                busy     = 1'b1;
                mem_addr = idx;
                if (idx == LAST_IDX) next_state = S_WR0;
            end
            S_WR0: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = AW'(RES_ADDR);
                mem_wr_data = ctb;
                next_state  = S_WR1;
            end
            S_WR1: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = AW'(RES_ADDR + 1);
                mem_wr_data = cto;
                next_state  = S_WR2;
            end
            S_WR2: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = AW'(RES_ADDR + 2);
                mem_wr_data = cts;
                next_state  = S_DONE;
            end
            S_DONE: begin
                ack        = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Pattern latch, byte index, previous nibble and the three match counters
    always_ff @(posedge clock) begin
        if (reset) begin
            pat  <= '0;
            prev <= '0;
            idx  <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    prev <= '0;
                    ctb  <= '0;
                    cto  <= '0;
                    cts  <= '0;
                end
                S_LOAD: begin
                    pat <= mem_rd_data[7:3];
                    idx <= '0;
                end
                S_SCAN: begin
                    ctb  <= ctb + CNT_W'(in_cnt);
                    cto  <= cto + CNT_W'(in_any);
                    cts  <= cts + CNT_W'(in_cnt) + CNT_W'(cross_cnt);
                    prev <= mem_rd_data[3:0];
                    idx  <= idx + AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed cases plus random
// strings/patterns checked against a bit-string reference model.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, req;
    logic       ack, busy, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

    logic [7:0] dm  [0:255];
    logic [7:0] str [32];
    logic [4:0] pat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl dut (
        .clock       (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    // Data memory: combinational read, clocked write
    assign mem_rd_data = dm[mem_addr];
    always @(posedge clk) if (mem_wr_en) dm[mem_addr] <= mem_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: treat the string as 256 bits, MSB of byte 0 first, and test
    // every 5-bit window position directly.
    function automatic void model(input logic [4:0] p, output int e_ctb, output int e_cto, output int e_cts);
        logic bits [256];
        int   hit  [32];
        bit   m;
        for (int i = 0; i < 256; i++) bits[i] = str[i / 8][7 - (i % 8)];
        for (int i = 0; i < 32; i++) hit[i] = 0;
        e_ctb = 0; e_cto = 0; e_cts = 0;
        for (int s = 0; s <= 251; s++) begin
            m = 1'b1;
            for (int j = 0; j < 5; j++) if (bits[s + j] != p[4 - j]) m = 1'b0;
            if (m) begin
                e_cts++;
                if ((s % 8) <= 3) begin
                    e_ctb++;
                    hit[s / 8] = 1;
                end
            end
        end
        for (int i = 0; i < 32; i++) e_cto += hit[i];
    endfunction

    task automatic fill(input logic [7:0] b);
        for (int i = 0; i < 32; i++) str[i] = b;
    endtask

    task automatic load_dm();
        for (int i = 0; i < 32; i++) dm[i] = str[i];
        dm[32] = {pat, 3'($urandom)};
        dm[33] = 8'hAA; dm[34] = 8'hAA; dm[35] = 8'hAA;
    endtask

    // One full run: pulse req, watch 45 cycles, check timing and results.
    task automatic run_scan(input string tag, input int e_ctb, input int e_cto, input int e_cts, input bit dup);
        int ack_cyc, acks, wrs, wr_bad, busy_bad;
        load_dm();
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        ack_cyc = -1; acks = 0; wrs = 0; wr_bad = 0; busy_bad = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = c;
            end
            if (mem_wr_en === 1'b1) begin
                wrs++;
                if (c < 34 || c > 36) wr_bad++;
            end
            if (busy !== ((c >= 1 && c <= 36) ? 1'b1 : 1'b0)) busy_bad++;
            if (dup && c == 10) req = 1'b1;
            if (dup && c == 11) req = 1'b0;
        end
        check({tag, " ack_latency"}, ack_cyc, 37);
        check({tag, " ack_count"}, acks, 1);
        check({tag, " write_count"}, wrs, 3);
        check({tag, " write_window"}, wr_bad, 0);
        check({tag, " busy_window"}, busy_bad, 0);
        check({tag, " ctb"}, dm[33], e_ctb);
        check({tag, " cto"}, dm[34], e_cto);
        check({tag, " cts"}, dm[35], e_cts);
    endtask

    task automatic run_model(input string tag);
        int a, b, c;
        model(pat, a, b, c);
        run_scan(tag, a, b, c, 1'b0);
    endtask

    initial begin
        int acks, wrs;
        reset = 1'b1;
        req   = 1'b0;
        for (int i = 0; i < 256; i++) dm[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack", ack, 0);
        check("reset busy", busy, 0);
        check("reset wr_en", mem_wr_en, 0);
        check("reset addr", mem_addr, 0);
        check("reset wr_data", mem_wr_data, 0);
        reset = 1'b0;
        @(negedge clk);

        pat = 5'b00000; fill(8'h00); run_scan("zeros", 128, 32, 252, 1'b0);
        pat = 5'b10101; fill(8'h55); run_scan("alt55", 64, 32, 126, 1'b0);
        pat = 5'b11111; fill(8'h00); run_scan("ones_vs_0", 0, 0, 0, 1'b0);
        pat = 5'b11111; fill(8'hFF); run_scan("ones_vs_ff", 128, 32, 252, 1'b0);
        pat = 5'b11111; fill(8'h00); str[0] = 8'h07; str[1] = 8'hC0;
        run_scan("crossing", 0, 0, 1, 1'b0);

        // Reset in the middle of a run: no writes, no ack, results untouched
        pat = 5'b00000; fill(8'h00); load_dm();
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", busy, 0);
        acks = 0; wrs = 0;
        for (int c = 0; c < 45; c++) begin
            if (ack === 1'b1) acks++;
            if (mem_wr_en === 1'b1) wrs++;
            @(negedge clk);
        end
        check("midreset acks", acks, 0);
        check("midreset writes", wrs, 0);
        check("midreset dm33", dm[33], 8'hAA);
        check("midreset dm34", dm[34], 8'hAA);
        check("midreset dm35", dm[35], 8'hAA);
        run_scan("after_reset", 128, 32, 252, 1'b0);

        // Second req mid-run must be ignored
        pat = 5'b10101; fill(8'h55); run_scan("dup_req", 64, 32, 126, 1'b1);

        // Random strings and patterns against the bit-string model
        for (int r = 0; r < 10; r++) begin
            pat = 5'($urandom);
            for (int i = 0; i < 32; i++)
                str[i] = (r < 5) ? 8'($urandom) : ($urandom_range(0, 1) ? {pat, 3'($urandom)} : 8'($urandom));
            run_model($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Hardware sequencer that runs the program-3 pattern search directly against data memory. On a `req` pulse it takes over the data-memory port and reads the 5-bit pattern from `DM[32]`. It then streams string bytes `DM[0..31]`, accumulates three match counts, and writes them to `DM[33..35]`. It sits beside the core in `top_level`, which muxes the data-memory port to this block while `busy` is high.

## Interface
Parameters:
- `STR_BYTES`, 32: number of string bytes scanned, starting at address 0.
- `PAT_ADDR`, 32: address of the pattern byte; pattern is in bits [7:3].
- `RES_ADDR`, 33: first result address; results go to `RES_ADDR`, `+1`, `+2`.
- `AW`, 8: data-memory address width.

Ports:
- `clock` — in — 1 — single clock; all state updates on the rising edge.
- `reset` — in — 1 — synchronous, active-high.
- `req` — in — 1 — start request, sampled only in IDLE.
- `ack` — out — 1 — one-cycle done pulse.
- `busy` — out — 1 — high from LOAD through WRITE; selects this block on the DM port.
- `mem_addr` — out — AW — DM address.
- `mem_rd_data` — in — 8 — DM read data; combinational read, valid in the same cycle as `mem_addr`.
- `mem_wr_en` — out — 1 — DM write strobe.
- `mem_wr_data` — out — 8 — DM write data.

## Operation
- **States:** IDLE → LOAD → SCAN → WR0 → WR1 → WR2 → DONE → IDLE.
- **IDLE:** `req`=1 goes to LOAD and clears the three counters and `prev` (4-bit register holding the previous byte's low nibble).
- **LOAD:**
  - `mem_addr`=`PAT_ADDR`.
  - Latch `pat` = `mem_rd_data[7:3]`.
  - Set byte index `idx`=0.
- **SCAN:** `mem_addr`=`idx`; let `b`=`mem_rd_data`.
  - **ctb** (in-byte count): add the number of matches among `b[4:0]`, `b[5:1]`, `b[6:2]`, `b[7:3]` (0–4).
  - **cto** (byte count): add 1 if any of those four windows matches.
  - **cts** (crossing count): add the in-byte count, plus, when `idx`>0, the crossing-window matches.
    - Crossing windows are taken from `w`={`prev`,`b`} (12 bits): `w[11:7]`, `w[10:6]`, `w[9:5]`, `w[8:4]`.
  - Then `prev`←`b[3:0]`; `idx`++.
  - Leave SCAN after `idx`=`STR_BYTES`−1.
- **String bit order:** byte 0 is most significant; within a byte, MSB first. The string therefore has 252 window positions: 4 + 31×8.
- **WR0/WR1/WR2:** `mem_wr_en`=1, writing in order:
  - `ctb` to `RES_ADDR`;
  - `cto` to `RES_ADDR`+1;
  - `cts` to `RES_ADDR`+2.
- **DONE:** `ack`=1 for exactly one cycle, then IDLE.
- **Count widths:** all counts are 8-bit. Maxima are ctb 128, cto 32, cts 252, so counts never wrap.
- **Boundary rules:**
  - `req` in any non-IDLE state is ignored; no queuing.
  - `req` held high through DONE starts a new run on the cycle after returning to IDLE.
  - `reset` in any state → IDLE on the next edge. Counters, `prev`, `idx` and `pat` clear; no further writes are issued; `ack` is not asserted.

## Timing
- **Reset values:** `ack`=0, `busy`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0.
- **Output decoding:** all outputs decode from registered state; no combinational path from `req` to outputs.
- **Cycle numbering:** cycle 0 is the edge sampling `req` in IDLE. From there:
  - LOAD in cycle 1;
  - SCAN in cycles 2..33;
  - writes in cycles 34..36;
  - `ack` high in cycle 37.
- **Latency:** `req` to `ack` is 1 + 1 + `STR_BYTES` + 3 cycles (37 at defaults).
- **busy:** high in cycles 1..36.
- **mem_wr_en:** high only in cycles 34..36.

## Structure
- **Package `pattern_scan_pkg`:**
  - state enum `scan_state_t`;
  - default address constants;
  - pattern width constant (5);
  - result-count width constant (8).
- **Sub-module `pattern_window_match`** (combinational), shared by ctb/cto/cts:
  - inputs: `pat`, 12-bit `w`, `first`;
  - outputs: `in_cnt`[2:0], `in_any`, `cross_cnt`[2:0].
  - `cross_cnt` is forced to 0 when `first`=1.
- **pattern_scan_ctrl** itself holds the FSM, counters and DM port drive.

## Test plan
- pat=00000, all bytes 0x00, pulse `req` → DM[33]=128, DM[34]=32, DM[35]=252; `ack` exactly 37 cycles after `req` sampled.
- pat=10101, all bytes 0x55 → 64, 32, 126.
- pat=11111, all bytes 0x00 → 0, 0, 0; pat=11111, all bytes 0xFF → 128, 32, 252.
- pat=11111, byte0=0x07, byte1=0xC0, rest 0x00 → ctb 0, cto 0, cts 1; checks crossing-only detection and bit order.
- Assert `reset` at cycle 15 of a run → `busy` 0 next cycle; no `mem_wr_en`; no `ack`; DM[33..35] unchanged. Re-`req` then gives correct results.
- Second `req` pulse at cycle 10 of a run is ignored: exactly one `ack` and one set of three writes.
